// File: rtl/slack_dual_update_if.sv
// Memory-side bus of the ADMM slack/dual stage.
// It carries two read-only primal ports (u, x) and four read/write ports
// for slack (z, v) and dual (y, g) memories.
interface slack_dual_update_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic        [ADDR_WIDTH-1:0] u_rdaddress;
  logic signed [DATA_WIDTH-1:0] u_data_out;

  logic        [ADDR_WIDTH-1:0] x_rdaddress;
  logic signed [DATA_WIDTH-1:0] x_data_out;

  logic        [ADDR_WIDTH-1:0] z_rdaddress;
  logic        [ADDR_WIDTH-1:0] z_wraddress;
  logic signed [DATA_WIDTH-1:0] z_data_out;
  logic signed [DATA_WIDTH-1:0] z_data_in;
  logic                         z_wren;

  logic        [ADDR_WIDTH-1:0] y_rdaddress;
  logic        [ADDR_WIDTH-1:0] y_wraddress;
  logic signed [DATA_WIDTH-1:0] y_data_out;
  logic signed [DATA_WIDTH-1:0] y_data_in;
  logic                         y_wren;

  logic        [ADDR_WIDTH-1:0] v_rdaddress;
  logic        [ADDR_WIDTH-1:0] v_wraddress;
  logic signed [DATA_WIDTH-1:0] v_data_out;
  logic signed [DATA_WIDTH-1:0] v_data_in;
  logic                         v_wren;

  logic        [ADDR_WIDTH-1:0] g_rdaddress;
  logic        [ADDR_WIDTH-1:0] g_wraddress;
  logic signed [DATA_WIDTH-1:0] g_data_out;
  logic signed [DATA_WIDTH-1:0] g_data_in;
  logic                         g_wren;

  // Stage side: drives addresses and write data, consumes read data.
  modport master (
    output u_rdaddress, input u_data_out,
    output x_rdaddress, input x_data_out,
    output z_rdaddress, z_wraddress, z_data_in, z_wren, input z_data_out,
    output y_rdaddress, y_wraddress, y_data_in, y_wren, input y_data_out,
    output v_rdaddress, v_wraddress, v_data_in, v_wren, input v_data_out,
    output g_rdaddress, g_wraddress, g_data_in, g_wren, input g_data_out
  );

  // Memory side.
  modport slave (
    input u_rdaddress, output u_data_out,
    input x_rdaddress, output x_data_out,
    input z_rdaddress, z_wraddress, z_data_in, z_wren, output z_data_out,
    input y_rdaddress, y_wraddress, y_data_in, y_wren, output y_data_out,
    input v_rdaddress, v_wraddress, v_data_in, v_wren, output v_data_out,
    input g_rdaddress, g_wraddress, g_data_in, g_wren, output g_data_out
  );
endinterface

// File: rtl/slack_dual_update.sv
// ADMM slack/dual stage.
// Each element is clamped into its box bound to give the new slack, and the
// scaled dual is updated in place. Max-abs primal and dual residuals are
// tracked separately for the input phase and the state phase.
module slack_dual_update #(
  parameter int unsigned STATE_DIM  = 12,
  parameter int unsigned INPUT_DIM  = 4,
  parameter int unsigned HORIZON    = 30,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [31:0]                  active_horizon,
  input  logic signed [DATA_WIDTH-1:0] rho,
  input  logic signed [DATA_WIDTH-1:0] u_min,
  input  logic signed [DATA_WIDTH-1:0] u_max,
  input  logic signed [DATA_WIDTH-1:0] x_min,
  input  logic signed [DATA_WIDTH-1:0] x_max,
  slack_dual_update_if.master          mem,
  output logic signed [DATA_WIDTH-1:0] pri_res_u,
  output logic signed [DATA_WIDTH-1:0] pri_res_x,
  output logic signed [DATA_WIDTH-1:0] dual_res_u,
  output logic signed [DATA_WIDTH-1:0] dual_res_x,
  output logic                         done
);

  localparam int unsigned SUM_W  = 18;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = 16;

  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, U_ADDR, U_WAIT, U_CALC, U_WRITE,
    X_ADDR, X_WAIT, X_CALC, X_WRITE, FINISH, DONE_ST
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              idx;
  logic [CNT_W-1:0]              eu_cnt;
  logic [CNT_W-1:0]              ex_cnt;
  logic signed [DATA_WIDTH-1:0]  max_pri_u;
  logic signed [DATA_WIDTH-1:0]  max_pri_x;
  logic signed [DATA_WIDTH-1:0]  max_dual_u;
  logic signed [DATA_WIDTH-1:0]  max_dual_x;

  // Clamp a wide signed value into the data word range.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PROD_W-1:0] a);
    if (a > PROD_W'(D_MAX))      sat = D_MAX;
    else if (a < PROD_W'(D_MIN)) sat = D_MIN;
    else                         sat = DATA_WIDTH'(a);
  endfunction

  // Absolute value; the most negative word maps to the most positive one.
  function automatic logic signed [DATA_WIDTH-1:0] sabs(input logic signed [DATA_WIDTH-1:0] a);
    if (a == D_MIN)            sabs = D_MAX;
    else if (a[DATA_WIDTH-1])  sabs = -a;
    else                       sabs = a;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sadd(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    sadd = sat(PROD_W'(s));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] ssub(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) - SUM_W'(b);
    ssub = sat(PROD_W'(s));
  endfunction

  // Element counts for the requested horizon, clamped to the maximum.
  logic [CNT_W-1:0] nh_c, eu_c, ex_c;
  always_comb begin
    nh_c = (active_horizon > 32'(HORIZON)) ? CNT_W'(HORIZON) : CNT_W'(active_horizon);
    eu_c = '0;
    if (nh_c > CNT_W'(1)) eu_c = CNT_W'(INPUT_DIM * 32'(nh_c - CNT_W'(1)));
    ex_c = CNT_W'(STATE_DIM * 32'(nh_c));
  end

  logic [ADDR_WIDTH-1:0] addr_c;
  assign addr_c = ADDR_WIDTH'(idx);

  // Per-element datapath, shared by both phases.
  logic signed [DATA_WIDTH-1:0] prim_c, dual_old_c, slack_old_c, lo_c, hi_c;
  logic signed [DATA_WIDTH-1:0] w_c, slack_new_c, dual_new_c, pri_c, dres_c;
  logic signed [SUM_W-1:0]      ynew_sum_c;
  logic signed [PROD_W-1:0]     prod_c;
  always_comb begin
    prim_c      = mem.u_data_out;
    dual_old_c  = mem.y_data_out;
    slack_old_c = mem.z_data_out;
    lo_c        = u_min;
    hi_c        = u_max;
    if (state == X_CALC) begin
      prim_c      = mem.x_data_out;
      dual_old_c  = mem.g_data_out;
      slack_old_c = mem.v_data_out;
      lo_c        = x_min;
      hi_c        = x_max;
    end
    w_c = sadd(prim_c, dual_old_c);
    if (w_c > hi_c)      slack_new_c = hi_c;
    else if (w_c < lo_c) slack_new_c = lo_c;
    else                 slack_new_c = w_c;
    ynew_sum_c = SUM_W'(dual_old_c) + SUM_W'(prim_c) - SUM_W'(slack_new_c);
    dual_new_c = sat(PROD_W'(ynew_sum_c));
    pri_c      = sabs(ssub(prim_c, slack_new_c));
    prod_c     = PROD_W'(rho) * PROD_W'(sabs(ssub(slack_new_c, slack_old_c)));
    dres_c     = sat(prod_c >>> FRAC_BITS);
  end

  // Sequencer: four cycles per element, input phase then state phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      eu_cnt          <= '0;
      ex_cnt          <= '0;
      max_pri_u       <= '0;
      max_pri_x       <= '0;
      max_dual_u      <= '0;
      max_dual_x      <= '0;
      pri_res_u       <= '0;
      pri_res_x       <= '0;
      dual_res_u      <= '0;
      dual_res_x      <= '0;
      done            <= 1'b0;
      mem.u_rdaddress <= '0;
      mem.x_rdaddress <= '0;
      mem.z_rdaddress <= '0;
      mem.y_rdaddress <= '0;
      mem.v_rdaddress <= '0;
      mem.g_rdaddress <= '0;
      mem.z_wraddress <= '0;
      mem.y_wraddress <= '0;
      mem.v_wraddress <= '0;
      mem.g_wraddress <= '0;
      mem.z_data_in   <= '0;
      mem.y_data_in   <= '0;
      mem.v_data_in   <= '0;
      mem.g_data_in   <= '0;
      mem.z_wren      <= 1'b0;
      mem.y_wren      <= 1'b0;
      mem.v_wren      <= 1'b0;
      mem.g_wren      <= 1'b0;
    end else begin
      mem.z_wren <= 1'b0;
      mem.y_wren <= 1'b0;
      mem.v_wren <= 1'b0;
      mem.g_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            max_pri_u  <= '0;
            max_pri_x  <= '0;
            max_dual_u <= '0;
            max_dual_x <= '0;
            eu_cnt     <= eu_c;
            ex_cnt     <= ex_c;
            idx        <= '0;
            if (eu_c != '0)      state <= U_ADDR;
            else if (ex_c != '0) state <= X_ADDR;
            else                 state <= FINISH;
          end
        end
        U_ADDR: begin
          mem.u_rdaddress <= addr_c;
          mem.z_rdaddress <= addr_c;
          mem.y_rdaddress <= addr_c;
          state           <= U_WAIT;
        end
        U_WAIT: state <= U_CALC;
        U_CALC: begin
          mem.z_data_in   <= slack_new_c;
          mem.y_data_in   <= dual_new_c;
          mem.z_wraddress <= addr_c;
          mem.y_wraddress <= addr_c;
          mem.z_wren      <= 1'b1;
          mem.y_wren      <= 1'b1;
          if (pri_c > max_pri_u)   max_pri_u  <= pri_c;
          if (dres_c > max_dual_u) max_dual_u <= dres_c;
          state <= U_WRITE;
        end
        U_WRITE: begin
          if (idx == eu_cnt - CNT_W'(1)) begin
            idx   <= '0;
            state <= (ex_cnt != '0) ? X_ADDR : FINISH;
          end else begin
            idx   <= idx + CNT_W'(1);
            state <= U_ADDR;
          end
        end
        X_ADDR: begin
          mem.x_rdaddress <= addr_c;
          mem.v_rdaddress <= addr_c;
          mem.g_rdaddress <= addr_c;
          state           <= X_WAIT;
        end
        X_WAIT: state <= X_CALC;
        X_CALC: begin
          mem.v_data_in   <= slack_new_c;
          mem.g_data_in   <= dual_new_c;
          mem.v_wraddress <= addr_c;
          mem.g_wraddress <= addr_c;
          mem.v_wren      <= 1'b1;
          mem.g_wren      <= 1'b1;
          if (pri_c > max_pri_x)   max_pri_x  <= pri_c;
          if (dres_c > max_dual_x) max_dual_x <= dres_c;
          state <= X_WRITE;
        end
        X_WRITE: begin
          if (idx == ex_cnt - CNT_W'(1)) begin
            idx   <= '0;
            state <= FINISH;
          end else begin
            idx   <= idx + CNT_W'(1);
            state <= X_ADDR;
          end
        end
        FINISH: begin
          pri_res_u  <= max_pri_u;
          pri_res_x  <= max_pri_x;
          dual_res_u <= max_dual_u;
          dual_res_x <= max_dual_x;
          state      <= DONE_ST;
        end
        DONE_ST: begin
          if (!done) begin
            done <= 1'b1;
          end else if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slack_dual_update.sv
// Scoreboard bench for slack_dual_update: expected memory writes are queued
// when a pass is launched and popped by a monitor on every write strobe.
module tb_slack_dual_update;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;
  localparam int NU = 4;
  localparam int NX = 12;
  localparam int HZ = 30;
  localparam int DEPTH = 512;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst, start, load;
  logic [31:0] active_horizon;
  logic signed [DW-1:0] rho, u_min, u_max, x_min, x_max;
  logic signed [DW-1:0] pri_res_u, pri_res_x, dual_res_u, dual_res_x;
  logic done;

  slack_dual_update_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

  slack_dual_update #(
    .STATE_DIM(NX), .INPUT_DIM(NU), .HORIZON(HZ),
    .DATA_WIDTH(DW), .FRAC_BITS(8), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
    .rho(rho), .u_min(u_min), .u_max(u_max), .x_min(x_min), .x_max(x_max),
    .mem(mem_if),
    .pri_res_u(pri_res_u), .pri_res_x(pri_res_x),
    .dual_res_u(dual_res_u), .dual_res_x(dual_res_x),
    .done(done)
  );

  always #5 clk = ~clk;

  // Memory models: registered read data, writes on the strobe, bulk load from init arrays.
  logic signed [DW-1:0] u_m [DEPTH], x_m [DEPTH], z_m [DEPTH], y_m [DEPTH], v_m [DEPTH], g_m [DEPTH];
  logic signed [DW-1:0] u_i [DEPTH], x_i [DEPTH], z_i [DEPTH], y_i [DEPTH], v_i [DEPTH], g_i [DEPTH];
  logic signed [DW-1:0] u_q, x_q, z_q, y_q, v_q, g_q;

  always @(posedge clk) begin
    u_q <= u_m[mem_if.u_rdaddress];
    x_q <= x_m[mem_if.x_rdaddress];
    z_q <= z_m[mem_if.z_rdaddress];
    y_q <= y_m[mem_if.y_rdaddress];
    v_q <= v_m[mem_if.v_rdaddress];
    g_q <= g_m[mem_if.g_rdaddress];
    if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        u_m[i] <= u_i[i]; x_m[i] <= x_i[i]; z_m[i] <= z_i[i];
        y_m[i] <= y_i[i]; v_m[i] <= v_i[i]; g_m[i] <= g_i[i];
      end
    end else begin
      if (mem_if.z_wren) z_m[mem_if.z_wraddress] <= mem_if.z_data_in;
      if (mem_if.y_wren) y_m[mem_if.y_wraddress] <= mem_if.y_data_in;
      if (mem_if.v_wren) v_m[mem_if.v_wraddress] <= mem_if.v_data_in;
      if (mem_if.g_wren) g_m[mem_if.g_wraddress] <= mem_if.g_data_in;
    end
  end

  assign mem_if.u_data_out = u_q;
  assign mem_if.x_data_out = x_q;
  assign mem_if.z_data_out = z_q;
  assign mem_if.y_data_out = y_q;
  assign mem_if.v_data_out = v_q;
  assign mem_if.g_data_out = g_q;

  int checks = 0;
  int failures = 0;
  wr_t zq[$], yq[$], vq[$], gq[$];
  int e_pri_u, e_pri_x, e_dual_u, e_dual_x, e_lat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input int sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    bit have;
    have = 1'b0;
    e = '0;
    case (sel)
      0: if (zq.size() > 0) begin e = zq.pop_front(); have = 1'b1; end
      1: if (yq.size() > 0) begin e = yq.pop_front(); have = 1'b1; end
      2: if (vq.size() > 0) begin e = vq.pop_front(); have = 1'b1; end
      default: if (gq.size() > 0) begin e = gq.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected write addr=%0d data=0x%04h", name, a, d);
    end else if (e.a !== a || e.d !== d) begin
      failures++;
      $display("FAIL %s: got addr=%0d data=0x%04h expected addr=%0d data=0x%04h", name, a, d, e.a, e.d);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_if.z_wren) sb_pop("z_write", 0, mem_if.z_wraddress, mem_if.z_data_in);
    if (mem_if.y_wren) sb_pop("y_write", 1, mem_if.y_wraddress, mem_if.y_data_in);
    if (mem_if.v_wren) sb_pop("v_write", 2, mem_if.v_wraddress, mem_if.v_data_in);
    if (mem_if.g_wren) sb_pop("g_write", 3, mem_if.g_wraddress, mem_if.g_data_in);
  end

  // Integer reference model.
  function automatic int clampi(input longint a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return int'(a);
  endfunction

  function automatic int absi(input int a);
    return (a < 0) ? clampi(-longint'(a)) : a;
  endfunction

  task automatic model_elem(input int p, input int d, input int so, input int lo, input int hi,
                            output int sn, output int dn, output int pr, output int du);
    int w;
    w = clampi(longint'(p) + d);
    if (w > hi) sn = hi;
    else if (w < lo) sn = lo;
    else sn = w;
    dn = clampi(longint'(d) + p - sn);
    pr = absi(clampi(longint'(p) - sn));
    du = clampi((longint'(rho) * absi(clampi(longint'(sn) - so))) >>> 8);
  endtask

  task automatic predict(input int nh_in);
    int nh, eu, ex, sn, dn, pr, du;
    wr_t w;
    nh = (nh_in > HZ) ? HZ : nh_in;
    eu = (nh > 1) ? NU * (nh - 1) : 0;
    ex = NX * nh;
    e_pri_u = 0; e_pri_x = 0; e_dual_u = 0; e_dual_x = 0;
    for (int e = 0; e < eu; e++) begin
      model_elem(u_m[e], y_m[e], z_m[e], u_min, u_max, sn, dn, pr, du);
      w.a = AW'(e); w.d = DW'(sn); zq.push_back(w);
      w.d = DW'(dn); yq.push_back(w);
      if (pr > e_pri_u) e_pri_u = pr;
      if (du > e_dual_u) e_dual_u = du;
    end
    for (int e = 0; e < ex; e++) begin
      model_elem(x_m[e], g_m[e], v_m[e], x_min, x_max, sn, dn, pr, du);
      w.a = AW'(e); w.d = DW'(sn); vq.push_back(w);
      w.d = DW'(dn); gq.push_back(w);
      if (pr > e_pri_x) e_pri_x = pr;
      if (du > e_dual_x) e_dual_x = du;
    end
    e_lat = 4 * (eu + ex) + 2;
  endtask

  task automatic clear_init();
    for (int i = 0; i < DEPTH; i++) begin
      u_i[i] = '0; x_i[i] = '0; z_i[i] = '0; y_i[i] = '0; v_i[i] = '0; g_i[i] = '0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      u_i[i] = DW'($urandom); x_i[i] = DW'($urandom); z_i[i] = DW'($urandom);
      y_i[i] = DW'($urandom); v_i[i] = DW'($urandom); g_i[i] = DW'($urandom);
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic run_pass(input int nh_in, input string tag);
    int n;
    predict(nh_in);
    @(negedge clk);
    active_horizon = 32'(nh_in);
    start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, e_lat);
    check({tag, ".pri_res_u"}, int'(pri_res_u), e_pri_u);
    check({tag, ".pri_res_x"}, int'(pri_res_x), e_pri_x);
    check({tag, ".dual_res_u"}, int'(dual_res_u), e_dual_u);
    check({tag, ".dual_res_x"}, int'(dual_res_x), e_dual_x);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".done_hold"}, int'(done), 1);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_clear"}, int'(done), 0);
    check({tag, ".writes_left"}, zq.size() + yq.size() + vq.size() + gq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b0; active_horizon = '0;
    rho = 16'sh0100;
    u_min = 16'shFF00; u_max = 16'sh0100;
    x_min = 16'shFF00; x_max = 16'sh0100;
    clear_init();
    repeat (3) @(posedge clk);
    #1;
    check("reset.done", int'(done), 0);
    check("reset.wren", int'({mem_if.z_wren, mem_if.y_wren, mem_if.v_wren, mem_if.g_wren}), 0);
    check("reset.residuals", int'({pri_res_u, pri_res_x, dual_res_u, dual_res_x} != '0), 0);
    check("reset.rdaddr", int'(mem_if.u_rdaddress) + int'(mem_if.x_rdaddress), 0);
    @(negedge clk); rst = 1'b0;
    load_mem();

    // Input clamped at the upper bound.
    clear_init();
    u_i[0] = 16'sh0200;
    load_mem();
    run_pass(2, "t1");
    check("t1.z0", int'(z_m[0]), 'h0100);
    check("t1.y0", int'(y_m[0]), 'h0100);
    check("t1.pri_u_hand", int'(pri_res_u), 'h0100);
    check("t1.dual_u_hand", int'(dual_res_u), 'h0100);

    // State sum saturating at the top of the range.
    clear_init();
    x_min = 16'sh8000; x_max = 16'sh7FFF;
    x_i[0] = 16'sh7F00; g_i[0] = 16'sh7F00;
    load_mem();
    run_pass(1, "t3");
    check("t3.v0", int'(v_m[0]), 'h7FFF);
    check("t3.g0", int'(g_m[0]), 'h7E01);
    check("t3.pri_x_hand", int'(pri_res_x), 'h00FF);
    check("t3.dual_x_hand", int'(dual_res_x), 'h7FFF);
    check("t3.pri_u_hand", int'(pri_res_u), 0);

    // Empty horizon: no writes, residuals forced to zero.
    run_pass(0, "t4_nh0");
    check("t4_nh0.pri_x_hand", int'(pri_res_x), 0);

    // Everything already inside the box: no change, zero residuals.
    clear_init();
    u_min = 16'shFC00; u_max = 16'sh0400;
    x_min = 16'shF000; x_max = 16'sh1000;
    for (int i = 0; i < 8; i++) begin
      u_i[i] = DW'(i * 32 - 128); z_i[i] = u_i[i];
    end
    for (int i = 0; i < 36; i++) begin
      x_i[i] = DW'((i % 8) * 256 - 768); v_i[i] = x_i[i];
    end
    load_mem();
    run_pass(3, "t2");
    check("t2.res_hand", int'({pri_res_u, pri_res_x, dual_res_u, dual_res_x} != '0), 0);

    // Random data over short, clamped and full horizons.
    rho = 16'sh0180;
    fill_random();
    load_mem();
    run_pass(1, "t4_nh1");
    fill_random();
    load_mem();
    run_pass(40, "t4_nh40");
    check("t4_nh40.latency_hand", e_lat, 1906);
    fill_random();
    load_mem();
    run_pass(30, "t5");

    // Reset in the calc cycle of state element 5.
    fill_random();
    load_mem();
    predict(1);
    @(negedge clk);
    active_horizon = 32'd1;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (22) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6.wren", int'({mem_if.z_wren, mem_if.y_wren, mem_if.v_wren, mem_if.g_wren}), 0);
    check("t6.residuals", int'({pri_res_u, pri_res_x, dual_res_u, dual_res_x} != '0), 0);
    check("t6.done", int'(done), 0);
    check("t6.wraddr", int'(mem_if.v_wraddress) + int'(mem_if.x_rdaddress), 0);
    check("t6.v_writes_left", vq.size(), 7);
    check("t6.g_writes_left", gq.size(), 7);
    zq.delete(); yq.delete(); vq.delete(); gq.delete();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (6) @(posedge clk);
    run_pass(2, "t6_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
